// File: rtl/rx_ipv4_pkg.sv
// Shared definitions for the IPv4 receive path: FSM encoding, header offsets
// and the one's-complement add used by the checksum accumulators.
package rx_ipv4_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HEADER   = 3'd1,
    PAYLOAD  = 3'd2,
    DROP     = 3'd3,
    DONE     = 3'd4,
    WAIT_END = 3'd5
  } state_t;

  localparam logic [5:0]  OFF_VER   = 6'd0;
  localparam logic [5:0]  OFF_LEN   = 6'd2;
  localparam logic [5:0]  OFF_PROTO = 6'd9;
  localparam logic [5:0]  OFF_SRC   = 6'd12;
  localparam logic [5:0]  OFF_DST   = 6'd16;

  localparam logic [3:0]  IPV4_VERSION   = 4'd4;
  localparam logic [3:0]  IPV4_MIN_IHL   = 4'd5;
  localparam logic [7:0]  IPV4_PROTO_UDP = 8'h11;
  localparam logic [31:0] IPV4_BCAST_IP  = 32'hFFFF_FFFF;
  localparam logic [15:0] CSUM_GOOD      = 16'hFFFF;

  // 17-bit add with the carry folded straight back in (end-around carry).
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage

// File: rtl/rx_ipv4_csum16.sv
// Byte-serial 16-bit one's-complement accumulator (even offsets = high byte).
// sum is look-ahead: it already includes the byte presented this cycle.
module ip_csum16
  import rx_ipv4_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  data_byte,
  input  logic        odd,
  output logic [15:0] sum
);

  logic [15:0] acc_q, acc_d, acc_base;
  logic [7:0]  hi_q, hi_d;

  always_comb begin
    acc_base = clear ? 16'h0000 : acc_q;
    if (en && odd) begin
      acc_d = csum_add(acc_base, {hi_q, data_byte});
    end else begin
      acc_d = acc_base;
    end
    hi_d = (en && !odd) ? data_byte : (clear ? 8'h00 : hi_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 16'h0000;
      hi_q  <= 8'h00;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
    end
  end

  assign sum = acc_d;

endmodule

// File: rtl/rx_ipv4.sv
// IPv4 receive stage: parses/validates the header of each MAC payload and
// forwards the UDP datagram bytes one cycle later.
module rx_ipv4 #(
  parameter int          OCT       = 8,
  parameter logic [7:0]  PROTO_UDP = rx_ipv4_pkg::IPV4_PROTO_UDP,
  parameter logic [31:0] BCAST_IP  = rx_ipv4_pkg::IPV4_BCAST_IP
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic           rx_irq_ipv4,
  output logic           rx_ip_err,
  output logic           rx_payload_udp,
  output logic [OCT-1:0] rx_udp_data,
  output logic [31:0]    rx_src_ip
);
  import rx_ipv4_pkg::*;

  state_t          state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [3:0]      ihl_q, ihl_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      proto_q, proto_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [15:0]     rem_q, rem_d;
  logic            armed_q, armed_d;
  logic            irq_q, irq_d;
  logic            err_q, err_d;
  logic            udp_v_q, udp_v_d;
  logic [OCT-1:0]  udp_data_q, udp_data_d;

  logic [7:0]      b_s;
  logic            start_s, hdr_byte_s, ver_ok_s, hdr_last_s, hdr_ok_s;
  logic [15:0]     hdr_len_s, csum_s;
  logic            csum_odd_s;

  // A frame may only start once the input has been seen low, so the tail of
  // a frame interrupted by reset (or of a finished packet) is never parsed.
  assign b_s        = rx_payload[7:0];
  assign start_s    = armed_q && rx_payload_ipv4 && ((state_q == IDLE) || (state_q == DONE));
  assign hdr_byte_s = (state_q == HEADER) && rx_payload_ipv4;
  assign ver_ok_s   = (b_s[7:4] == IPV4_VERSION) && (b_s[3:0] >= IPV4_MIN_IHL);
  assign hdr_len_s  = {10'd0, ihl_q, 2'b00};
  assign hdr_last_s = (cnt_q == ({ihl_q, 2'b00} - 6'd1));
  assign csum_odd_s = start_s ? 1'b0 : cnt_q[0];

  ip_csum16 u_csum (
    .clk       (RX_CLK),
    .rst       (rst),
    .clear     (start_s),
    .en        (start_s || hdr_byte_s),
    .data_byte (b_s),
    .odd       (csum_odd_s),
    .sum       (csum_s)
  );

  always_comb begin
    ihl_d   = start_s ? b_s[3:0] : ihl_q;
    len_d   = (hdr_byte_s && ((cnt_q == OFF_LEN) || (cnt_q == OFF_LEN + 6'd1)))
              ? {len_q[7:0], b_s} : len_q;
    proto_d = (hdr_byte_s && (cnt_q == OFF_PROTO)) ? b_s : proto_q;
    src_d   = (hdr_byte_s && (cnt_q >= OFF_SRC) && (cnt_q < OFF_DST))
              ? {src_q[23:0], b_s} : src_q;
    dst_d   = (hdr_byte_s && (cnt_q >= OFF_DST) && (cnt_q < OFF_DST + 6'd4))
              ? {dst_q[23:0], b_s} : dst_q;
  end

  // dst_d already holds the final destination byte when it is the last header byte.
  assign hdr_ok_s = (csum_s == CSUM_GOOD) && (len_q >= hdr_len_s) &&
                    ((dst_d == ip_addr) || (dst_d == BCAST_IP)) && (proto_q == PROTO_UDP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    udp_v_d    = 1'b0;
    udp_data_d = udp_data_q;
    err_d      = 1'b0;
    armed_d    = start_s ? 1'b0 : (rx_payload_ipv4 ? armed_q : 1'b1);
    case (state_q)
      IDLE, DONE: begin
        if (start_s) begin
          cnt_d   = 6'd1;
          state_d = ver_ok_s ? HEADER : DROP;
        end else if ((state_q == DONE) && rx_payload_ipv4) begin
          state_d = WAIT_END;
        end else begin
          state_d = IDLE;
        end
      end
      HEADER: begin
        if (!rx_payload_ipv4) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (hdr_last_s && hdr_ok_s) begin
          rem_d   = len_q - hdr_len_s;
          state_d = (len_q == hdr_len_s) ? DONE : PAYLOAD;
        end else if (hdr_last_s) begin
          state_d = DROP;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      PAYLOAD: begin
        if (!rx_payload_ipv4) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          udp_v_d    = 1'b1;
          udp_data_d = rx_payload;
          rem_d      = rem_q - 16'd1;
          state_d    = (rem_q == 16'd1) ? DONE : PAYLOAD;
        end
      end
      DROP: begin
        if (!rx_payload_ipv4) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      WAIT_END: begin
        state_d = rx_payload_ipv4 ? WAIT_END : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    irq_d = (state_d == DONE);
  end

  always_ff @(posedge RX_CLK) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 6'd0;
      ihl_q      <= 4'd0;
      len_q      <= 16'd0;
      proto_q    <= 8'd0;
      src_q      <= 32'd0;
      dst_q      <= 32'd0;
      rem_q      <= 16'd0;
      armed_q    <= 1'b0;
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      udp_v_q    <= 1'b0;
      udp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ihl_q      <= ihl_d;
      len_q      <= len_d;
      proto_q    <= proto_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      rem_q      <= rem_d;
      armed_q    <= armed_d;
      irq_q      <= irq_d;
      err_q      <= err_d;
      udp_v_q    <= udp_v_d;
      udp_data_q <= udp_data_d;
    end
  end

  assign rx_irq_ipv4    = irq_q;
  assign rx_ip_err      = err_q;
  assign rx_payload_udp = udp_v_q;
  assign rx_udp_data    = udp_data_q;
  assign rx_src_ip      = src_q;

endmodule

// File: tb/tb_rx_ipv4.sv
// Scoreboard bench for rx_ipv4: directed frames push expected outputs (with
// their expected cycle) and a negedge monitor pops and compares them.
module tb_rx_ipv4;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic [31:0] ip_addr;
  logic        rx_payload_ipv4;
  logic [7:0]  rx_payload;
  logic        rx_irq_ipv4, rx_ip_err, rx_payload_udp;
  logic [7:0]  rx_udp_data;
  logic [31:0] rx_src_ip;

  rx_ipv4 dut (
    .RX_CLK          (RX_CLK),
    .rst             (rst),
    .ip_addr         (ip_addr),
    .rx_payload_ipv4 (rx_payload_ipv4),
    .rx_payload      (rx_payload),
    .rx_irq_ipv4     (rx_irq_ipv4),
    .rx_ip_err       (rx_ip_err),
    .rx_payload_udp  (rx_payload_udp),
    .rx_udp_data     (rx_udp_data),
    .rx_src_ip       (rx_src_ip)
  );

  always #5 RX_CLK = ~RX_CLK;

  typedef struct {
    bit          is_irq;
    logic [7:0]  data;
    bit          err;
    logic [31:0] src;
    int          at;
  } exp_t;

  localparam logic [31:0] ME  = 32'hC0A8_010A;
  localparam logic [31:0] SRC = 32'hC0A8_0102;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  frm[$];
  exp_t        stage_q[$];
  exp_t        sb_q[$];
  exp_t        mon_e;

  always @(posedge RX_CLK) cyc <= cyc + 1;

  always @(negedge RX_CLK) begin
    if (rx_payload_udp) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL udp_byte: got %02h at cycle %0d, expected no output", rx_udp_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (mon_e.is_irq || (mon_e.data !== rx_udp_data) || (mon_e.at != cyc)) begin
          errors++;
          $display("FAIL udp_byte: got byte %02h at cycle %0d, expected %s %02h at cycle %0d",
                   rx_udp_data, cyc, mon_e.is_irq ? "irq" : "byte", mon_e.data, mon_e.at);
        end
      end
    end
    if (rx_irq_ipv4) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL irq: got irq err=%0b at cycle %0d, expected no output", rx_ip_err, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (!mon_e.is_irq || (mon_e.err != rx_ip_err) || (mon_e.at != cyc) ||
            (!mon_e.err && (mon_e.src !== rx_src_ip))) begin
          errors++;
          $display("FAIL irq: got irq err=%0b src=%08h at cycle %0d, expected %s err=%0b src=%08h at cycle %0d",
                   rx_ip_err, rx_src_ip, cyc, mon_e.is_irq ? "irq" : "byte", mon_e.err, mon_e.src, mon_e.at);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (rx_irq_ipv4 !== 1'b0 || rx_ip_err !== 1'b0 || rx_payload_udp !== 1'b0 ||
        rx_udp_data !== 8'h00 || rx_src_ip !== 32'h0) begin
      errors++;
      $display("FAIL %s: got irq=%b err=%b udp=%b data=%02h src=%08h, expected all zero",
               name, rx_irq_ipv4, rx_ip_err, rx_payload_udp, rx_udp_data, rx_src_ip);
    end
  endtask

  task automatic build(input logic [7:0] b0, input logic [15:0] tlen, input logic [7:0] proto,
                       input logic [15:0] ck, input logic [31:0] dst, input int nopt,
                       input int npay, input logic [7:0] pbase, input int npad);
    logic [7:0] v;
    frm.delete();
    frm.push_back(b0);         frm.push_back(8'h00);
    frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
    frm.push_back(8'h00);      frm.push_back(8'h00);
    frm.push_back(8'h40);      frm.push_back(8'h00);
    frm.push_back(8'h40);      frm.push_back(proto);
    frm.push_back(ck[15:8]);   frm.push_back(ck[7:0]);
    frm.push_back(SRC[31:24]); frm.push_back(SRC[23:16]);
    frm.push_back(SRC[15:8]);  frm.push_back(SRC[7:0]);
    frm.push_back(dst[31:24]); frm.push_back(dst[23:16]);
    frm.push_back(dst[15:8]);  frm.push_back(dst[7:0]);
    for (int i = 0; i < nopt; i++) frm.push_back(8'h01);
    v = pbase;
    for (int i = 0; i < npay; i++) begin
      frm.push_back(v);
      v = v + 8'd1;
    end
    for (int i = 0; i < npad; i++) frm.push_back(8'hEE);
  endtask

  // rel = cycle offset from the cycle in which frame byte 0 is driven.
  task automatic exp_payload(input int first_idx, input int n, input logic [7:0] base);
    exp_t e;
    logic [7:0] v;
    v = base;
    for (int k = 0; k < n; k++) begin
      e.is_irq = 1'b0; e.data = v; e.err = 1'b0; e.src = 32'h0; e.at = first_idx + k + 1;
      stage_q.push_back(e);
      v = v + 8'd1;
    end
  endtask

  task automatic exp_irq(input bit err, input int rel);
    exp_t e;
    e.is_irq = 1'b1; e.data = 8'h00; e.err = err; e.src = SRC; e.at = rel;
    stage_q.push_back(e);
  endtask

  task automatic play(input int gap, input int rst_at);
    int t0;
    exp_t e;
    @(negedge RX_CLK);
    t0 = cyc;
    foreach (stage_q[i]) begin
      e = stage_q[i];
      e.at = e.at + t0;
      sb_q.push_back(e);
    end
    stage_q.delete();
    for (int i = 0; i < frm.size(); i++) begin
      if (i > 0) @(negedge RX_CLK);
      if (rst_at >= 0 && i == rst_at + 1) check_zero("mid_reset");
      rst = (i == rst_at);
      rx_payload_ipv4 = 1'b1;
      rx_payload = frm[i];
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge RX_CLK);
      rst = 1'b0;
      rx_payload_ipv4 = 1'b0;
      rx_payload = 8'h00;
    end
  endtask

  initial begin
    rst = 1'b1;
    ip_addr = ME;
    rx_payload_ipv4 = 1'b0;
    rx_payload = 8'h00;
    repeat (3) @(negedge RX_CLK);
    check_zero("reset");
    rst = 1'b0;

    // good UDP packet with Ethernet padding
    build(8'h45, 16'h001E, 8'h11, 16'hB772, ME, 0, 10, 8'h00, 16);
    exp_payload(20, 10, 8'h00); exp_irq(1'b0, 30); play(4, -1);
    // bad checksum
    build(8'h45, 16'h001E, 8'h11, 16'hB773, ME, 0, 10, 8'h00, 16);
    exp_irq(1'b1, 47); play(4, -1);
    // foreign destination, checksum valid
    build(8'h45, 16'h001E, 8'h11, 16'hB6E3, 32'hC0A8_0199, 0, 10, 8'h00, 16);
    exp_irq(1'b1, 47); play(4, -1);
    // broadcast destination accepted
    build(8'h45, 16'h001E, 8'h11, 16'h7925, 32'hFFFF_FFFF, 0, 10, 8'h30, 16);
    exp_payload(20, 10, 8'h30); exp_irq(1'b0, 30); play(4, -1);
    // TCP protocol dropped
    build(8'h45, 16'h001E, 8'h06, 16'hB77D, ME, 0, 10, 8'h00, 16);
    exp_irq(1'b1, 47); play(4, -1);
    // IHL=6 with a 4-byte option: payload starts at byte 24
    build(8'h46, 16'h0022, 8'h11, 16'hB46C, ME, 4, 10, 8'hA0, 16);
    exp_payload(24, 10, 8'hA0); exp_irq(1'b0, 34); play(4, -1);
    // version 5 rejected at byte 0
    build(8'h55, 16'h001E, 8'h11, 16'hB772, ME, 0, 10, 8'h00, 16);
    exp_irq(1'b1, 47); play(4, -1);
    // total length equals header: completion right after the header
    build(8'h45, 16'h0014, 8'h11, 16'hB77C, ME, 0, 0, 8'h00, 6);
    exp_irq(1'b0, 20); play(4, -1);
    // total length shorter than header
    build(8'h45, 16'h0010, 8'h11, 16'hB780, ME, 0, 0, 8'h00, 10);
    exp_irq(1'b1, 31); play(4, -1);
    // truncated after payload byte 4
    build(8'h45, 16'h001E, 8'h11, 16'hB772, ME, 0, 5, 8'h00, 0);
    exp_payload(20, 5, 8'h00); exp_irq(1'b1, 26); play(4, -1);
    // reset during header byte 8: rest of frame must be ignored
    build(8'h45, 16'h001E, 8'h11, 16'hB772, ME, 0, 10, 8'h00, 16);
    play(4, 8);
    // next frame parses normally
    build(8'h45, 16'h001E, 8'h11, 16'hB772, ME, 0, 10, 8'h60, 16);
    exp_payload(20, 10, 8'h60); exp_irq(1'b0, 30); play(4, -1);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge RX_CLK);
    repeat (5) @(negedge RX_CLK);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outputs still pending, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
